seven_seg_capture: RTL and testbench
====================================

# seven_seg_capture

Receive-side companion to the team's multiplexed 8-digit seven-segment driver. It samples the one-hot digit-select and segment lines, waits for each digit to settle, decodes segment patterns back to BCD, and assembles one full scan into a BCD triple and an 8-bit binary value. It is used as a loopback/readback monitor on the display bus, or to capture an external display using the same encoding.

## Interface
- STABLE_CYCLES, 4: cycles a {digit, seg} pair must stay unchanged after synchronisation before it is captured (≥2).
- TIMEOUT_W, 19: the frame times out after 2^TIMEOUT_W cycles with no capture.
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- digit_in  in  8  digit select, one-hot, active-high; bit7 = leftmost, bit0 = ones
- seg_in  in  7  segment pattern, bit6..bit0 = g..a, active-high
- value  out  8  binary value of the last completed frame
- bcd  out  12  {hundreds, tens, ones} of the last completed frame
- valid  out  1  one-cycle pulse when value/bcd/seg_err/range_err update
- seg_err  out  1  last frame contained an undecodable pattern
- range_err  out  1  last frame had nonzero digits 7..3, or value > 255
- frame_err  out  1  one-cycle pulse: a stable non-one-hot, non-zero digit_in
- timeout_err  out  1  one-cycle pulse: frame abandoned by timeout

## Operation
- Both inputs pass through a two-flop synchroniser. All further logic uses the synchronised copies.
- Settle counter:
  - Cleared whenever the synchronised {digit, seg} differs from the previous cycle; otherwise increments, saturating.
  - When the count reaches STABLE_CYCLES-1, one capture event fires. A per-dwell flag allows only one capture until the inputs change again.
- Capture event, by digit value:
  - Exactly one bit set: decode seg into slot[k], where k is the bit index, and set seen[k]. A slot captured again before the frame completes is overwritten (latest wins).
  - digit == 0 (blanking): ignored, no error.
  - Two or more bits set: frame_err pulses, seen is cleared, and slot contents are discarded.
- Decode table (a..g encoding, same as the driver):
  - 0 = 0111111, 1 = 0000110, 2 = 1011011, 3 = 1001111, 4 = 1100110
  - 5 = 1101101, 6 = 1111101, 7 = 0100111, 8 = 1111111, 9 = 1101111
  - Any other pattern stores 4'hF, marked invalid.
- FSM states:
  - COLLECT: reset state. Moves to COMPUTE when seen == 8'hFF.
  - COMPUTE: forms sum = slot2*100 + slot1*10 + slot0 in 10 bits (max 999). Goes to EMIT.
  - EMIT: updates outputs, pulses valid, clears seen. Goes to COLLECT.
- Capture events arriving during COMPUTE or EMIT are held, to be applied in COLLECT. They can only occur there after ≥STABLE_CYCLES, so nothing is lost.
- Output rules in EMIT:
  - bcd = {slot2, slot1, slot0}.
  - seg_err = 1 if any slot holds 4'hF.
  - range_err = 1 if any of slot7..slot3 is nonzero, or sum > 255.
  - value = sum[7:0] if neither error is set, else 8'hFF (saturated).
- Timeout: a counter is cleared on every capture event and runs in COLLECT. On reaching 2^TIMEOUT_W-1 with seen ≠ 0:
  - timeout_err pulses and seen is cleared.
  - The counter holds at 0 while seen == 0.

## Timing
- Reset values (asynchronous): value 0, bcd 0, valid 0, all err outputs 0, seen 0, FSM in COLLECT, synchroniser flops 0.
- Capture latency: a pair applied at cycle t is captured at cycle t+2+STABLE_CYCLES-1. This includes the 2-cycle synchroniser.
- If the capture completing seen occurs at cycle N:
  - COMPUTE at N+1.
  - EMIT at N+2. valid is high during N+2, and outputs are registered so they are stable from N+2 onward.
- valid never stays high for two consecutive cycles. value/bcd/seg_err/range_err hold until the next EMIT.
- frame_err and timeout_err pulse one cycle after the triggering event.
- If frame_err and timeout_err would fire in the same cycle, frame_err wins and timeout_err is suppressed.
- reset_n asserted mid-frame: everything returns to reset values immediately, and the partial frame is discarded.
- The driver's refresh (2^17 cycles per digit) gives a nominal frame of 2^20 cycles. The default timeout covers 4 missing digit dwells.

## Test plan
- Scan digits 7..0 showing 0,0,0,0,0,2,5,5; dwell 20 cycles each, STABLE_CYCLES = 4 -> one valid pulse; value = 8'hFF, bcd = 12'h255, seg_err = 0, range_err = 0.
- Same scan showing ..0,1,2,8 -> value = 128, bcd = 12'h128. Rescan with slot1 replaced by 1110000 -> seg_err = 1, value = 8'hFF.
- Show 2,6,0 in slots 2..0 -> range_err = 1, value = 8'hFF, bcd = 12'h260. Show nonzero slot5 with 0,4,2 -> range_err = 1.
- Apply digit_in = 8'b00000110 stably mid-frame -> frame_err pulses once, and no valid is produced until 8 fresh captures follow. digit_in = 0 for 50 cycles -> no error.
- Present digits 7..4, then hold digit_in = 0 for 2^TIMEOUT_W cycles (TIMEOUT_W = 6 in sim) -> timeout_err pulses, no valid; a following full scan yields a correct valid.
- Toggle seg_in every 2 cycles with STABLE_CYCLES = 4 -> no capture. Assert reset_n after 5 of 8 captures -> all outputs 0, and a fresh full scan is required for valid.

Source files
------------

// File: rtl/seven_seg_capture.sv
// Readback monitor for the multiplexed 8-digit seven-segment bus: settles, decodes and
// assembles one full scan into BCD and binary, flagging bad patterns, bad selects and timeouts.
module seven_seg_capture #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned TIMEOUT_W     = 19
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  digit_in,
    input  logic [6:0]  seg_in,
    output logic [7:0]  value,
    output logic [11:0] bcd,
    output logic        valid,
    output logic        seg_err,
    output logic        range_err,
    output logic        frame_err,
    output logic        timeout_err
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]     CNT_FIRE = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [TIMEOUT_W-1:0] TMO_MAX  = '1;

    typedef enum logic [1:0] {COLLECT, COMPUTE, EMIT} state_t;

    state_t               state, state_nxt;
    logic [7:0]           dig_s1, dig_s2, dig_p;
    logic [6:0]           seg_s1, seg_s2, seg_p;
    logic [CNT_W-1:0]     cnt;
    logic                 done;
    logic                 pend;
    logic [7:0]           pend_dig;
    logic [6:0]           pend_seg;
    logic [7:0]           seen;
    logic [3:0]           slot [8];
    logic [TIMEOUT_W-1:0] tcnt;

    logic       changed_c, capture_c, evt_c, onehot_c, multi_c;
    logic [7:0] evt_dig_c;
    logic [6:0] evt_seg_c;
    logic [2:0] evt_idx_c;
    logic [3:0] evt_val_c;
    logic [9:0] sum_c;
    logic       seg_err_c, high_c, range_c;

    function automatic logic [3:0] decode(input logic [6:0] s);
        case (s)
            7'b0111111: return 4'd0;
            7'b0000110: return 4'd1;
            7'b1011011: return 4'd2;
            7'b1001111: return 4'd3;
            7'b1100110: return 4'd4;
            7'b1101101: return 4'd5;
            7'b1111101: return 4'd6;
            7'b0100111: return 4'd7;
            7'b1111111: return 4'd8;
            7'b1101111: return 4'd9;
            default:    return 4'hF;
        endcase
    endfunction

    // Two-flop synchroniser plus the previous-cycle copy used for change detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dig_s1 <= '0; dig_s2 <= '0; dig_p <= '0;
            seg_s1 <= '0; seg_s2 <= '0; seg_p <= '0;
        end else begin
            dig_s1 <= digit_in; dig_s2 <= dig_s1; dig_p <= dig_s2;
            seg_s1 <= seg_in;   seg_s2 <= seg_s1; seg_p <= seg_s2;
        end
    end

    assign changed_c = ({dig_s2, seg_s2} != {dig_p, seg_p});
    assign capture_c = !changed_c && (cnt == CNT_FIRE) && !done;

    // Settle counter saturates, so one dwell yields at most one capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            done <= 1'b0;
        end else if (changed_c) begin
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
            if (capture_c) done <= 1'b1;
        end
    end

    // Captures landing while the frame is being emitted wait here for COLLECT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend     <= 1'b0;
            pend_dig <= '0;
            pend_seg <= '0;
        end else if (capture_c && state != COLLECT) begin
            pend     <= 1'b1;
            pend_dig <= dig_p;
            pend_seg <= seg_p;
        end else if (state == COLLECT) begin
            pend <= 1'b0;
        end
    end

    always_comb begin
        evt_c     = (state == COLLECT) && (capture_c || pend);
        evt_dig_c = capture_c ? dig_p : pend_dig;
        evt_seg_c = capture_c ? seg_p : pend_seg;
        evt_val_c = decode(evt_seg_c);
        onehot_c  = (evt_dig_c != 8'd0) && ((evt_dig_c & (evt_dig_c - 8'd1)) == 8'd0);
        multi_c   = (evt_dig_c != 8'd0) && !onehot_c;
        evt_idx_c = '0;
        for (int i = 0; i < 8; i++) begin
            if (evt_dig_c[i]) evt_idx_c = 3'(i);
        end
    end

    // Slot capture, frame abandonment and the inactivity timeout
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen        <= '0;
            tcnt        <= '0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            for (int i = 0; i < 8; i++) slot[i] <= '0;
        end else begin
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            if (evt_c) begin
                tcnt <= '0;
                if (multi_c) begin
                    seen      <= '0;
                    frame_err <= 1'b1;
                end else if (onehot_c) begin
                    seen[evt_idx_c] <= 1'b1;
                    slot[evt_idx_c] <= evt_val_c;
                end
            end else if (state == EMIT) begin
                seen <= '0;
                tcnt <= '0;
            end else if (state == COLLECT) begin
                if (seen == 8'd0) begin
                    tcnt <= '0;
                end else if (tcnt == TMO_MAX) begin
                    tcnt        <= '0;
                    seen        <= '0;
                    timeout_err <= 1'b1;
                end else begin
                    tcnt <= tcnt + TIMEOUT_W'(1);
                end
            end
        end
    end

    always_comb begin
        sum_c     = 10'(slot[2]) * 10'd100 + 10'(slot[1]) * 10'd10 + 10'(slot[0]);
        seg_err_c = 1'b0;
        high_c    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (slot[i] == 4'hF) seg_err_c = 1'b1;
            if (i >= 3 && slot[i] != 4'd0) high_c = 1'b1;
        end
        range_c = high_c || (sum_c > 10'd255);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= COLLECT;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (seen == 8'hFF) state_nxt = COMPUTE;
            COMPUTE: state_nxt = EMIT;
            EMIT:    state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // Results are registered on the way into EMIT so valid and data appear together
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value     <= '0;
            bcd       <= '0;
            valid     <= 1'b0;
            seg_err   <= 1'b0;
            range_err <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (state == COMPUTE) begin
                valid     <= 1'b1;
                bcd       <= {slot[2], slot[1], slot[0]};
                seg_err   <= seg_err_c;
                range_err <= range_c;
                value     <= (seg_err_c || range_c) ? 8'hFF : sum_c[7:0];
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed and randomized scans of seven_seg_capture checked against a digit-level model
// of the frame: per-slot values, seen set, and the expected result of each completed scan.
module tb_seven_seg_capture;

    localparam int unsigned STABLE = 4;
    localparam int unsigned TW     = 6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  digit_in;
    logic [6:0]  seg_in;
    logic [7:0]  value;
    logic [11:0] bcd;
    logic        valid, seg_err, range_err, frame_err, timeout_err;

    seven_seg_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_W(TW)) dut (
        .clk(clk), .reset_n(reset_n), .digit_in(digit_in), .seg_in(seg_in),
        .value(value), .bcd(bcd), .valid(valid), .seg_err(seg_err),
        .range_err(range_err), .frame_err(frame_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Pulse counters seen by the monitor
    int obs_valid = 0, obs_frame = 0, obs_tmo = 0;
    bit dbl_valid = 1'b0, prev_valid = 1'b0;

    always @(negedge clk) begin
        if (valid) begin
            obs_valid <= obs_valid + 1;
            if (prev_valid) dbl_valid <= 1'b1;
        end
        if (frame_err)   obs_frame <= obs_frame + 1;
        if (timeout_err) obs_tmo   <= obs_tmo + 1;
        prev_valid <= valid;
    end

    // Reference model: digit values per slot (15 = undecodable) and which slots are filled
    int m_slot [8];
    bit m_seen [8];
    int exp_valid = 0, exp_frame = 0, exp_tmo = 0;
    int exp_value = 0, exp_bcd = 0;
    bit exp_seg = 1'b0, exp_range = 1'b0, range_known = 1'b1;

    localparam logic [6:0] BAD = 7'b1110000;

    function automatic logic [6:0] enc(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0100111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return BAD;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic bit any_seen();
        for (int i = 0; i < 8; i++) if (m_seen[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic clear_seen();
        for (int i = 0; i < 8; i++) m_seen[i] = 1'b0;
    endtask

    task automatic frame_result();
        int h, t, o, sum;
        bit hi, low_bad;
        h = m_slot[2]; t = m_slot[1]; o = m_slot[0];
        hi = 1'b0; low_bad = 1'b0; exp_seg = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (m_slot[i] == 15) exp_seg = 1'b1;
            if (i >= 3 && m_slot[i] != 0) hi = 1'b1;
            if (i < 3 && m_slot[i] == 15) low_bad = 1'b1;
        end
        sum = h * 100 + t * 10 + o;
        exp_range   = hi || (sum > 255);
        range_known = hi || !low_bad;
        exp_value   = (exp_seg || exp_range) ? 255 : sum;
        exp_bcd     = (h << 8) | (t << 4) | o;
        exp_valid++;
        clear_seen();
    endtask

    task automatic model_event(input logic [7:0] d, input int v);
        if (d == 8'd0) return;
        if ($countones(d) == 1) begin
            for (int i = 0; i < 8; i++) begin
                if (d[i]) begin
                    m_slot[i] = v;
                    m_seen[i] = 1'b1;
                end
            end
            begin
                bit all;
                all = 1'b1;
                for (int i = 0; i < 8; i++) if (!m_seen[i]) all = 1'b0;
                if (all) frame_result();
            end
        end else begin
            exp_frame++;
            clear_seen();
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/valid_cnt"}, obs_valid, exp_valid);
        check({tag, "/frame_cnt"}, obs_frame, exp_frame);
        check({tag, "/tmo_cnt"},   obs_tmo,   exp_tmo);
        check({tag, "/value"},     32'(value), 32'(exp_value));
        check({tag, "/bcd"},       32'(bcd),   32'(exp_bcd));
        check({tag, "/seg_err"},   32'(seg_err), 32'(exp_seg));
        if (range_known) check({tag, "/range_err"}, 32'(range_err), 32'(exp_range));
    endtask

    task automatic dwell(input logic [7:0] d, input int v, input int cyc);
        @(negedge clk);
        digit_in = d;
        seg_in   = enc(v);
        repeat (cyc) @(negedge clk);
        model_event(d, v);
    endtask

    task automatic idle(input int cyc);
        @(negedge clk);
        digit_in = 8'd0;
        seg_in   = 7'd0;
        repeat (cyc) @(negedge clk);
        if (cyc > (1 << TW) + 16 && any_seen()) begin
            exp_tmo++;
            clear_seen();
        end
    endtask

    // Full scan, leftmost digit first; vals[k] is the value shown in slot k
    task automatic scan(input int vals [8], input string tag);
        for (int k = 7; k >= 0; k--) dwell(8'(1 << k), vals[k], 20);
        idle(10);
        check_all(tag);
    endtask

    initial begin
        int v [8];
        int ord [8];

        for (int i = 0; i < 8; i++) begin
            m_slot[i] = 0;
            m_seen[i] = 1'b0;
        end
        reset_n  = 1'b0;
        digit_in = 8'd0;
        seg_in   = 7'd0;
        repeat (3) @(negedge clk);
        check("reset/value", 32'(value), 32'd0);
        check("reset/bcd",   32'(bcd),   32'd0);
        check("reset/flags", 32'({valid, seg_err, range_err, frame_err, timeout_err}), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        v = '{5, 5, 2, 0, 0, 0, 0, 0};
        scan(v, "scan255");
        v = '{8, 2, 1, 0, 0, 0, 0, 0};
        scan(v, "scan128");
        v = '{8, 15, 1, 0, 0, 0, 0, 0};
        scan(v, "segbad");
        v = '{0, 6, 2, 0, 0, 0, 0, 0};
        scan(v, "range260");
        v = '{2, 4, 0, 0, 0, 3, 0, 0};
        scan(v, "range_hi");

        // Multi-bit select mid-frame abandons the frame; blanking is harmless
        for (int k = 7; k >= 4; k--) dwell(8'(1 << k), 0, 20);
        dwell(8'b0000_0110, 3, 20);
        idle(50);
        for (int k = 3; k >= 0; k--) dwell(8'(1 << k), k, 20);
        idle(10);
        check_all("frame_err");
        v = '{7, 3, 1, 0, 0, 0, 0, 0};
        scan(v, "after_ferr");

        // Blank gap inside a frame stays below the timeout
        for (int k = 7; k >= 3; k--) dwell(8'(1 << k), 0, 20);
        idle(50);
        for (int k = 2; k >= 0; k--) dwell(8'(1 << k), 9 - k, 20);
        idle(10);
        check_all("blank50");

        // Timeout on a partial frame, then a full scan recovers
        for (int k = 7; k >= 4; k--) dwell(8'(1 << k), 0, 20);
        idle(100);
        check_all("timeout");
        v = '{9, 9, 1, 0, 0, 0, 0, 0};
        scan(v, "after_tmo");

        // seg_in toggling every 2 cycles never settles, so slot1 stays unfilled
        for (int k = 7; k >= 2; k--) dwell(8'(1 << k), 0, 20);
        @(negedge clk);
        digit_in = 8'b0000_0010;
        for (int i = 0; i < 20; i++) begin
            seg_in = (i % 2 == 0) ? enc(3) : enc(7);
            repeat (2) @(negedge clk);
        end
        dwell(8'b0000_0001, 6, 20);
        idle(10);
        check_all("toggle");
        dwell(8'b0000_0010, 4, 20);
        idle(10);
        check_all("toggle_fill");

        // Reset mid-frame clears everything and discards the partial frame
        for (int k = 7; k >= 3; k--) dwell(8'(1 << k), 0, 20);
        @(negedge clk);
        reset_n  = 1'b0;
        digit_in = 8'd0;
        seg_in   = 7'd0;
        #1;
        check("rst_mid/value", 32'(value), 32'd0);
        check("rst_mid/bcd",   32'(bcd),   32'd0);
        check("rst_mid/flags", 32'({valid, seg_err, range_err, frame_err, timeout_err}), 32'd0);
        clear_seen();
        for (int i = 0; i < 8; i++) m_slot[i] = 0;
        exp_value = 0; exp_bcd = 0; exp_seg = 1'b0; exp_range = 1'b0; range_known = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 2; k >= 0; k--) dwell(8'(1 << k), 1, 20);
        idle(10);
        check_all("rst_partial");
        v = '{3, 4, 0, 0, 0, 0, 0, 0};
        scan(v, "rst_full");

        // Randomized scans: shuffled order, rescans, blanks, occasional bad/high digits
        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < 8; i++) ord[i] = i;
            for (int i = 7; i > 0; i--) begin
                int j, tmp;
                j = int'($urandom_range(0, i));
                tmp = ord[i]; ord[i] = ord[j]; ord[j] = tmp;
            end
            for (int i = 0; i < 8; i++) begin
                int k, val;
                k = ord[i];
                if (k < 3) val = int'($urandom_range(0, 9));
                else       val = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 9)) : 0;
                if ($urandom_range(0, 11) == 0) val = 15;
                if (i == 1 && $urandom_range(0, 1) == 1) begin
                    dwell(8'(1 << ord[0]), int'($urandom_range(0, 9)), int'($urandom_range(10, 30)));
                    idle(int'($urandom_range(10, 20)));
                end
                dwell(8'(1 << k), val, int'($urandom_range(10, 30)));
                if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(10, 30)));
            end
            idle(10);
            check_all("random");
        end

        check("no_double_valid", 32'(dbl_valid), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
